// File: rtl/async_fifo_wr_ctrl_if.sv
// Write-side bundle of the dual-clock FIFO: upstream valid/ready stream plus memory write port.
// slave is the controller view; master is the upstream/memory environment view.
interface async_fifo_wr_ctrl_if #(
  parameter int unsigned DW = 4,
  parameter int unsigned AW = 3
);
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready,
    input  mem_we,
    input  mem_waddr,
    input  mem_wdata
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready,
    output mem_we,
    output mem_waddr,
    output mem_wdata
  );
endinterface

// File: rtl/async_fifo_wr_ctrl.sv
// Write-domain controller of a dual-clock FIFO: pointers, read-pointer sync, full/level/overflow.
// Define WR_SYNC3_EN for a three-stage read-pointer synchroniser (high-frequency clk_wrt).
module async_fifo_wr_ctrl #(
  parameter int unsigned DW        = 4,
  parameter int unsigned AW        = 3,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic                 clk_wrt,
  input  logic                 reset,
  async_fifo_wr_ctrl_if.slave  wr_if,
  input  logic [AW:0]          rd_ptr_gray_in,
  output logic [AW:0]          wr_ptr_gray_out,
  output logic                 full,
  output logic                 almost_full,
  output logic [AW:0]          wr_level,
  input  logic                 ovf_clr,
  output logic                 overflow
);

  localparam int unsigned Depth    = 1 << AW;
  localparam int unsigned AfInt    = Depth - AF_MARGIN;
  localparam logic [AW:0] AfThresh = AfInt[AW:0];
  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
  localparam logic [AW:0] FullFlip = {2'b11, {(AW - 1){1'b0}}};

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = int'(AW) - 1; i >= 0; i--) begin
      b[i] = b[i + 1] ^ g[i];
    end
    return b;
  endfunction

  logic [AW:0] wr_bin_q, wr_bin_d;
  logic [AW:0] wr_gray_q, wr_gray_d;
  logic [AW:0] rq1_q, rq2_q;
  logic [AW:0] rptr_sync;
  logic        almost_full_q, almost_full_d;
  logic        overflow_q, overflow_d;
  logic        accept;

`ifdef WR_SYNC3_EN
  logic [AW:0] rq3_q;

  always_ff @(posedge clk_wrt) begin
    if (reset) begin
      rq3_q <= '0;
    end else begin
      rq3_q <= rq2_q;
    end
  end

  assign rptr_sync = rq3_q;
`else
  assign rptr_sync = rq2_q;
`endif

  always_comb begin
    full          = (wr_gray_q == (rptr_sync ^ FullFlip));
    wr_level      = wr_bin_q - gray2bin(rptr_sync);
    // Reset drops any write presented in the same cycle.
    accept        = wr_if.wr_valid && !full && !reset;
    wr_bin_d      = accept ? wr_bin_q + (AW + 1)'(1) : wr_bin_q;
    wr_gray_d     = wr_bin_d ^ (wr_bin_d >> 1);
    almost_full_d = (wr_level >= AfThresh);
    overflow_d    = overflow_q;
    if (wr_if.wr_valid && full) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_wrt) begin
    if (reset) begin
      wr_bin_q      <= '0;
      wr_gray_q     <= '0;
      rq1_q         <= '0;
      rq2_q         <= '0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_bin_q      <= wr_bin_d;
      wr_gray_q     <= wr_gray_d;
      rq1_q         <= rd_ptr_gray_in;
      rq2_q         <= rq1_q;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  assign wr_ptr_gray_out = wr_gray_q;
  assign almost_full     = almost_full_q;
  assign overflow        = overflow_q;

  assign wr_if.wr_ready  = !full;
  assign wr_if.mem_we    = accept;
  assign wr_if.mem_waddr = wr_bin_q[AW-1:0];
  assign wr_if.mem_wdata = wr_if.wr_data;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Self-checking bench for async_fifo_wr_ctrl: vector table for fill/overflow, hand sequences for
// read release, wrap and mid-burst reset; memory writes checked against a scoreboard queue.
module tb_async_fifo_wr_ctrl;
  localparam int unsigned DW = 4;
  localparam int unsigned AW = 3;
`ifdef WR_SYNC3_EN
  localparam int unsigned NSync = 3;
`else
  localparam int unsigned NSync = 2;
`endif

  logic          clk_wrt = 1'b0;
  logic          reset   = 1'b1;
  logic [AW:0]   rd_ptr_gray_in = '0;
  logic [AW:0]   wr_ptr_gray_out;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wr_level;
  logic          ovf_clr = 1'b0;
  logic          overflow;

  async_fifo_wr_ctrl_if #(.DW(DW), .AW(AW)) wr_if ();

  async_fifo_wr_ctrl #(.DW(DW), .AW(AW), .AF_MARGIN(2)) dut (
    .clk_wrt         (clk_wrt),
    .reset           (reset),
    .wr_if           (wr_if),
    .rd_ptr_gray_in  (rd_ptr_gray_in),
    .wr_ptr_gray_out (wr_ptr_gray_out),
    .full            (full),
    .almost_full     (almost_full),
    .wr_level        (wr_level),
    .ovf_clr         (ovf_clr),
    .overflow        (overflow)
  );

  always #5 clk_wrt = ~clk_wrt;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [AW:0] gray(input int b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_exp_t;

  wr_exp_t sb_q[$];

  // Memory-side monitor: every strobe must match the oldest expected write.
  always @(negedge clk_wrt) begin
    wr_exp_t e;
    if (wr_if.mem_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL mem_write: unexpected write addr %0d data %0d, expected no write",
                 wr_if.mem_waddr, wr_if.mem_wdata);
      end else begin
        e = sb_q.pop_front();
        check("mem_waddr", int'(wr_if.mem_waddr), int'(e.addr));
        check("mem_wdata", int'(wr_if.mem_wdata), int'(e.data));
      end
    end
  end

  task automatic push_wr(input int addr, input int data);
    wr_exp_t e;
    e.addr = addr[AW-1:0];
    e.data = data[DW-1:0];
    sb_q.push_back(e);
  endtask

  task automatic edge_step();
    @(posedge clk_wrt);
    #1;
  endtask

  typedef struct {
    logic          valid;
    logic [DW-1:0] data;
    logic          clr;
    logic          exp_we;
    logic          exp_full;
    logic          exp_af;
    logic          exp_ovf;
    logic [AW:0]   exp_level;
    logic [AW:0]   exp_gray;
  } vec_t;

  vec_t vecs[12];

  task automatic set_vec(input int i, input bit valid, input int data, input bit clr,
                         input bit we, input bit fl, input bit af, input bit ovf,
                         input int level, input int bin);
    vecs[i].valid     = valid;
    vecs[i].data      = data[DW-1:0];
    vecs[i].clr       = clr;
    vecs[i].exp_we    = we;
    vecs[i].exp_full  = fl;
    vecs[i].exp_af    = af;
    vecs[i].exp_ovf   = ovf;
    vecs[i].exp_level = level[AW:0];
    vecs[i].exp_gray  = gray(bin);
  endtask

  initial begin
    bit          prev_full;
    int          cnt;
    logic [AW:0] prev_gray;

    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = '0;

    // Fill to full, then overflow attempts and clear/set priority.
    for (int k = 0; k < 8; k++) set_vec(k, 1, k + 1, 0, 1, k == 7, k >= 6, 0, k + 1, k + 1);
    set_vec(8,  1, 9,  0, 0, 1, 1, 1, 8, 8);
    set_vec(9,  1, 10, 0, 0, 1, 1, 1, 8, 8);
    set_vec(10, 0, 0,  1, 0, 1, 1, 0, 8, 8);
    set_vec(11, 1, 11, 1, 0, 1, 1, 1, 8, 8);

    // Reset held 3 cycles with a write presented; nothing may reach memory.
    edge_step();
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = 4'd5;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("rst_mem_we", int'(wr_if.mem_we), 0);
      edge_step();
    end
    reset          = 1'b0;
    wr_if.wr_valid = 1'b0;
    #1;
    check("rst_full", int'(full), 0);
    check("rst_ready", int'(wr_if.wr_ready), 1);
    check("rst_level", int'(wr_level), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_gray", int'(wr_ptr_gray_out), 0);
    check("rst_af", int'(almost_full), 0);
    check("rst_mem_we_idle", int'(wr_if.mem_we), 0);

    prev_full = 1'b0;
    for (int i = 0; i < 12; i++) begin
      wr_if.wr_valid = vecs[i].valid;
      wr_if.wr_data  = vecs[i].data;
      ovf_clr        = vecs[i].clr;
      #1;
      check($sformatf("v%0d_we", i), int'(wr_if.mem_we), int'(vecs[i].exp_we));
      check($sformatf("v%0d_ready", i), int'(wr_if.wr_ready), int'(!prev_full));
      if (vecs[i].exp_we) push_wr(i, int'(vecs[i].data));
      edge_step();
      check($sformatf("v%0d_full", i), int'(full), int'(vecs[i].exp_full));
      check($sformatf("v%0d_level", i), int'(wr_level), int'(vecs[i].exp_level));
      check($sformatf("v%0d_gray", i), int'(wr_ptr_gray_out), int'(vecs[i].exp_gray));
      check($sformatf("v%0d_af", i), int'(almost_full), int'(vecs[i].exp_af));
      check($sformatf("v%0d_ovf", i), int'(overflow), int'(vecs[i].exp_ovf));
      prev_full = vecs[i].exp_full;
    end

    // Read side frees entries: full must hold until the synchroniser delivers them.
    wr_if.wr_valid = 1'b0;
    ovf_clr        = 1'b0;
    rd_ptr_gray_in = 4'b0001;
    for (int e = 1; e <= int'(NSync); e++) begin
      edge_step();
      check($sformatf("release_full_e%0d", e), int'(full), (e < int'(NSync)) ? 1 : 0);
    end
    rd_ptr_gray_in = 4'b0011;
    repeat (NSync) edge_step();
    check("release_level", int'(wr_level), 6);
    check("release_ready", int'(wr_if.wr_ready), 1);
    check("release_af", int'(almost_full), 1);
    check("release_ovf_sticky", int'(overflow), 1);
    ovf_clr = 1'b1;
    edge_step();
    ovf_clr = 1'b0;
    check("ovf_clr", int'(overflow), 0);

    // Continuous writes with the read pointer trailing; pointer must wrap 15 -> 0.
    rd_ptr_gray_in = '0;
    reset          = 1'b1;
    edge_step();
    reset     = 1'b0;
    cnt       = 0;
    prev_gray = '0;
    for (int i = 0; i < 20; i++) begin
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = i[DW-1:0];
      rd_ptr_gray_in = gray(cnt);
      #1;
      check($sformatf("wrap%0d_ready", i), int'(wr_if.wr_ready), 1);
      push_wr(cnt % 8, i);
      edge_step();
      cnt++;
      check($sformatf("wrap%0d_gray", i), int'(wr_ptr_gray_out), int'(gray(cnt % 16)));
      check($sformatf("wrap%0d_onebit", i), $countones(wr_ptr_gray_out ^ prev_gray), 1);
      check($sformatf("wrap%0d_full", i), int'(full), 0);
      prev_gray = wr_ptr_gray_out;
    end
    wr_if.wr_valid = 1'b0;
    rd_ptr_gray_in = gray(cnt);
    repeat (3) edge_step();

    // Reset in the middle of a 5-write burst, after write 3.
    rd_ptr_gray_in = '0;
    reset          = 1'b1;
    edge_step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = DW'(i + 1);
      push_wr(i, i + 1);
      edge_step();
    end
    reset         = 1'b1;
    wr_if.wr_data = 4'd4;
    #1;
    check("midrst_mem_we", int'(wr_if.mem_we), 0);
    edge_step();
    reset = 1'b0;
    check("midrst_gray", int'(wr_ptr_gray_out), 0);
    check("midrst_level", int'(wr_level), 0);
    check("midrst_full", int'(full), 0);
    for (int i = 0; i < 2; i++) begin
      wr_if.wr_data = DW'(i + 4);
      #1;
      check($sformatf("postrst%0d_waddr", i), int'(wr_if.mem_waddr), i);
      push_wr(i, i + 4);
      edge_step();
    end
    wr_if.wr_valid = 1'b0;
    repeat (2) edge_step();
    check("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
